ita_tile_sequencer: RTL

- Sequences the tiled execution of one ITA matrix job: it walks the S/P/E tile loop, computes per-tile stream base addresses and issues one tile command per iteration to the streamer control logic.
- Sits between the HWPE register file (tile counts, base pointers, strides) and the per-tile streamer/engine start logic.
- It waits for tile completion before issuing the next tile, and signals job completion to the slave controller.

---
 rtl/ita_tile_sequencer.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/ita_tile_sequencer.sv
// ita_tile_sequencer: walks the S/P/E tile loop of one ITA matrix job and
// issues one tile command per iteration, with per-tile stream base addresses
// kept in running registers (no multipliers).
// Optional build macro ITA_TILE_SEQ_PREFETCH_EN: allow up to two tiles in
// flight instead of strict issue/wait alternation.
module ita_tile_sequencer #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned TILE_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              start_i,
   input  logic [TILE_W-1:0] tile_s_i,
   input  logic [TILE_W-1:0] tile_e_i,
   input  logic [TILE_W-1:0] tile_p_i,
   input  logic [ADDR_W-1:0] input_base_i,
   input  logic [ADDR_W-1:0] weight_base_i,
   input  logic [ADDR_W-1:0] output_base_i,
   input  logic [ADDR_W-1:0] input_stride_i,
   input  logic [ADDR_W-1:0] weight_stride_i,
   input  logic [ADDR_W-1:0] output_stride_i,
   output logic              cmd_valid_o,
   input  logic              cmd_ready_i,
   output logic [ADDR_W-1:0] cmd_input_addr_o,
   output logic [ADDR_W-1:0] cmd_weight_addr_o,
   output logic [ADDR_W-1:0] cmd_output_addr_o,
   output logic              cmd_first_e_o,
   output logic              cmd_last_e_o,
   input  logic              tile_done_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

   state_t            state, state_next;
   logic [TILE_W-1:0] s, p, e, s_max, p_max, e_max;
   logic [ADDR_W-1:0] in_addr, in_row, w_addr, w_base, out_addr;
   logic [ADDR_W-1:0] in_stride, w_stride, out_stride;
   logic              load, adv, set_err, accept, last_tile, err;

   // A tile count of zero behaves as one, so the last index is count-1 floored at 0.
   function automatic logic [TILE_W-1:0] cnt_max(input logic [TILE_W-1:0] c);
      return (c == '0) ? '0 : c - 1'b1;
   endfunction

   assign accept    = cmd_valid_o && cmd_ready_i;
   assign last_tile = (e == e_max) && (p == p_max) && (s == s_max);

   assign cmd_input_addr_o  = in_addr;
   assign cmd_weight_addr_o = w_addr;
   assign cmd_output_addr_o = out_addr;
   assign cmd_first_e_o     = cmd_valid_o && (e == '0);
   assign cmd_last_e_o      = cmd_valid_o && (e == e_max);
   assign err_o             = err;

`ifdef ITA_TILE_SEQ_PREFETCH_EN
   logic [1:0] outst;
   logic       remain;
   logic       done_ok;

   assign done_ok = tile_done_i && (outst != 2'd0);

   // Outstanding-tile counter and "commands still to issue" flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outst  <= 2'd0;
         remain <= 1'b0;
      end else if (clear_i || load) begin
         outst  <= 2'd0;
         remain <= load && !clear_i;
      end else begin
         if (accept && !done_ok)      outst <= outst + 2'd1;
         else if (!accept && done_ok) outst <= outst - 2'd1;
         if (accept && last_tile)     remain <= 1'b0;
      end
   end

   // Next state and outputs; the loop position advances on every accept.
   always_comb begin
      state_next  = state;
      load        = 1'b0;
      adv         = 1'b0;
      set_err     = 1'b0;
      cmd_valid_o = 1'b0;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) begin
               load       = 1'b1;
               state_next = ISSUE;
            end
            if (tile_done_i) set_err = 1'b1;
         end
         ISSUE: begin
            busy_o      = 1'b1;
            cmd_valid_o = remain && (outst != 2'd2);
            if (accept && !last_tile) adv = 1'b1;
            if (tile_done_i && (outst == 2'd0)) set_err = 1'b1;
            if (tile_done_i && (outst == 2'd1) && !accept && !remain) state_next = FIN;
         end
         FIN: begin
            done_o     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (clear_i) begin
         state_next  = IDLE;
         load        = 1'b0;
         adv         = 1'b0;
         set_err     = 1'b0;
         cmd_valid_o = 1'b0;
         done_o      = 1'b0;
      end
   end
`else
   // Next state and outputs; one tile in flight, loop advances on tile completion.
   always_comb begin
      state_next  = state;
      load        = 1'b0;
      adv         = 1'b0;
      set_err     = 1'b0;
      cmd_valid_o = 1'b0;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) begin
               load       = 1'b1;
               state_next = ISSUE;
            end
            if (tile_done_i) set_err = 1'b1;
         end
         ISSUE: begin
            busy_o      = 1'b1;
            cmd_valid_o = 1'b1;
            if (tile_done_i) set_err = 1'b1;
            if (accept) state_next = WAIT;
         end
         WAIT: begin
            busy_o = 1'b1;
            if (tile_done_i) begin
               if (last_tile) begin
                  state_next = FIN;
               end else begin
                  adv        = 1'b1;
                  state_next = ISSUE;
               end
            end
         end
         FIN: begin
            done_o     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (clear_i) begin
         state_next  = IDLE;
         load        = 1'b0;
         adv         = 1'b0;
         set_err     = 1'b0;
         cmd_valid_o = 1'b0;
         done_o      = 1'b0;
      end
   end
`endif

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_next;
   end

   // Sticky spurious-completion flag, cleared by a new job or a soft clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)               err <= 1'b0;
      else if (clear_i || load)  err <= 1'b0;
      else if (set_err)          err <= 1'b1;
   end

   // Loop counters and running addresses: e innermost, then p, then s.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s <= '0; p <= '0; e <= '0;
         s_max <= '0; p_max <= '0; e_max <= '0;
         in_addr <= '0; in_row <= '0; w_addr <= '0; w_base <= '0; out_addr <= '0;
         in_stride <= '0; w_stride <= '0; out_stride <= '0;
      end else if (load) begin
         s <= '0; p <= '0; e <= '0;
         s_max <= cnt_max(tile_s_i);
         p_max <= cnt_max(tile_p_i);
         e_max <= cnt_max(tile_e_i);
         in_addr    <= input_base_i;
         in_row     <= input_base_i;
         w_addr     <= weight_base_i;
         w_base     <= weight_base_i;
         out_addr   <= output_base_i;
         in_stride  <= input_stride_i;
         w_stride   <= weight_stride_i;
         out_stride <= output_stride_i;
      end else if (adv) begin
         if (e != e_max) begin
            e       <= e + 1'b1;
            in_addr <= in_addr + in_stride;
            w_addr  <= w_addr + w_stride;
         end else if (p != p_max) begin
            // New p column: input rewinds to the start of the current s row.
            e        <= '0;
            p        <= p + 1'b1;
            in_addr  <= in_row;
            w_addr   <= w_addr + w_stride;
            out_addr <= out_addr + out_stride;
         end else begin
            // New s row: input moves past the finished row, weights restart.
            e        <= '0;
            p        <= '0;
            s        <= s + 1'b1;
            in_addr  <= in_addr + in_stride;
            in_row   <= in_addr + in_stride;
            w_addr   <= w_base;
            out_addr <= out_addr + out_stride;
         end
      end
   end

endmodule
